// File: rtl/conv_window_ctrl_if.sv
// Stream, PE and control signals of the 3x3 convolution window sequencer.
// The slave modport is the sequencer side; the master modport is its environment.
interface conv_window_ctrl_if #(
  parameter int DW = 16
);
  logic            i_start;
  logic            i_reuse_w;
  logic [DW-1:0]   i_in_d;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [9*DW-1:0] o_wbus;
  logic [9*DW-1:0] o_winbus;
  logic [DW-1:0]   i_pe_d;
  logic [DW-1:0]   o_y;
  logic            o_y_valid;
  logic            i_y_ready;
  logic            o_y_last;
  logic            o_busy;
  logic            o_done;

  modport slave (
    input  i_start, i_reuse_w, i_in_d, i_in_valid, i_pe_d, i_y_ready,
    output o_in_ready, o_wbus, o_winbus, o_y, o_y_valid, o_y_last, o_busy, o_done
  );

  modport master (
    output i_start, i_reuse_w, i_in_d, i_in_valid, i_pe_d, i_y_ready,
    input  o_in_ready, o_wbus, o_winbus, o_y, o_y_valid, o_y_last, o_busy, o_done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Buffers 9 weights and an IMG x IMG frame, then walks every 3x3 window in
// row-major order through one shared external PE and streams the results out.
module conv_window_ctrl #(
  parameter int IMG = 6,
  parameter int DW  = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  conv_window_ctrl_if.slave  bus
);
  localparam int OUT = IMG - 2;
  localparam int NPX = IMG * IMG;
  localparam int CW  = $clog2(NPX);
  localparam int PAW = $clog2(NPX);
  localparam int RW  = $clog2(OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_LOAD_D, S_RUN} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [RW-1:0]          r_r;
  logic [RW-1:0]          r_c;
  logic                   r_all_cap;
  logic signed [DW-1:0]   r_w  [9];
  logic signed [DW-1:0]   r_px [NPX];
  logic signed [DW-1:0]   r_y;
  logic                   r_y_valid;
  logic                   r_y_last;
  logic                   r_in_ready;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_adv;
  logic                   w_win_last;
  logic [PAW-1:0]         w_idx;
  logic [9*DW-1:0]        w_wbus;
  logic [9*DW-1:0]        w_winbus;

  assign w_accept   = bus.i_in_valid & r_in_ready;
  assign w_adv      = (~r_y_valid | bus.i_y_ready) & ~r_all_cap;
  assign w_win_last = (r_r == RW'(OUT - 1)) && (r_c == RW'(OUT - 1));

  // Window element k sits at row r+k/3, column c+k%3 of the buffered frame.
  always_comb begin
    w_idx    = '0;
    w_wbus   = '0;
    w_winbus = '0;
    for (int k = 0; k < 9; k++) begin
      w_idx = PAW'((int'(r_r) + k / 3) * IMG + int'(r_c) + k % 3);
      w_winbus[DW*k +: DW] = r_px[w_idx];
      w_wbus[DW*k +: DW]   = r_w[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_all_cap  <= 1'b0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
      r_y_last   <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int k = 0; k < 9; k++) r_w[k] <= '0;
      for (int n = 0; n < NPX; n++) r_px[n] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state    <= bus.i_reuse_w ? S_LOAD_D : S_LOAD_W;
            r_cnt      <= '0;
            r_r        <= '0;
            r_c        <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD_W: begin
          if (w_accept) begin
            r_w[r_cnt[3:0]] <= bus.i_in_d;
            if (r_cnt == CW'(8)) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_D;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LOAD_D: begin
          if (w_accept) begin
            r_px[r_cnt] <= bus.i_in_d;
            if (r_cnt == CW'(NPX - 1)) begin
              r_cnt      <= '0;
              r_r        <= '0;
              r_c        <= '0;
              r_all_cap  <= 1'b0;
              r_in_ready <= 1'b0;
              r_state    <= S_RUN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_RUN: begin
          // A new capture may replace a word that handshakes in the same cycle.
          if (w_adv) begin
            r_y       <= bus.i_pe_d;
            r_y_valid <= 1'b1;
            r_y_last  <= w_win_last;
            if (w_win_last) begin
              r_all_cap <= 1'b1;
            end else if (r_c == RW'(OUT - 1)) begin
              r_c <= '0;
              r_r <= r_r + RW'(1);
            end else begin
              r_c <= r_c + RW'(1);
            end
          end else if (r_y_valid && bus.i_y_ready) begin
            r_y_valid <= 1'b0;
            r_y_last  <= 1'b0;
            if (r_y_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_in_ready = r_in_ready;
  assign bus.o_wbus     = w_wbus;
  assign bus.o_winbus   = w_winbus;
  assign bus.o_y        = r_y;
  assign bus.o_y_valid  = r_y_valid;
  assign bus.o_y_last   = r_y_last;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
endmodule
